// File: rtl/ssd_keypad_scan.sv
// ssd_keypad_scan
//
// Scans a 4x4 matrix keypad and delivers debounced key presses to a CPU-facing
// register interface. One column is driven low at a time, and the column index
// rotates at a software-set rate. The rows are sampled once per column slot.
// A full scan frame is classified as no key, a single key or several keys.
// A small FSM accepts a single key after DB_FRAMES identical frames and releases
// it after DB_FRAMES empty frames. Each accepted key is emitted exactly once.
//
// Parameters:
//   RATE_W     width of the scan-rate divisor
//   DB_FRAMES  consecutive identical frames needed to accept a press or a
//              release (1..15)
//
// Ports:
//   clk        system clock
//   rst_n      asynchronous active-low reset; clears all state while low
//   rate       clock cycles per column slot; 0 freezes the scan
//   row        keypad rows, active-low, asynchronous to clk
//   col        keypad column drive, active-low, exactly one bit low
//   key_code   accepted key, code = 4*row_index + col_index
//   key_valid  key_code holds an undelivered key
//   key_ready  consumer accepts key_code when key_valid is also high
//   overflow   sticky flag, set when a press is dropped
//   ovf_clr    single-cycle clear of overflow

module ssd_keypad_scan #(
  parameter int RATE_W    = 16,
  parameter int DB_FRAMES = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [RATE_W-1:0] rate,
  input  logic [3:0]        row,
  output logic [3:0]        col,
  output logic [3:0]        key_code,
  output logic              key_valid,
  input  logic              key_ready,
  output logic              overflow,
  input  logic              ovf_clr
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DEBOUNCE = 2'd1,
    HELD     = 2'd2
  } db_state_t;

  localparam logic [3:0] DB_LIMIT = 4'(DB_FRAMES);

  logic [3:0]        row_meta;
  logic [3:0]        row_s;
  logic [RATE_W-1:0] div_cnt;
  logic              tick;
  logic [1:0]        col_idx;
  logic [3:0]        mask0;
  logic [3:0]        mask1;
  logic [3:0]        mask2;
  logic              frame_done;
  logic [15:0]       snapshot;
  logic [4:0]        bit_cnt;
  logic [3:0]        single_code;
  logic              snap_none;
  logic              snap_single;

  db_state_t         state;
  db_state_t         state_next;
  logic [3:0]        db_cnt;
  logic [3:0]        db_cnt_next;
  logic [3:0]        cand;
  logic [3:0]        cand_next;
  logic [3:0]        db_inc;
  logic              emit;
  logic [3:0]        emit_code;
  logic              drop;

  // Two-flop synchroniser for the asynchronous row inputs. The reset value
  // is the idle (pulled-up) level, so nothing reads as pressed after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_meta <= 4'hF;
      row_s    <= 4'hF;
    end else begin
      row_meta <= row;
      row_s    <= row_meta;
    end
  end

  // The tick fires when the divisor matches rate-1. When rate is lowered
  // below the current count, the counter keeps running and wraps through
  // zero before it can match again. A rate of zero parks the counter.
  assign tick = (rate != '0) && (div_cnt == (rate - RATE_W'(1)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt <= '0;
    end else if (rate == '0) begin
      div_cnt <= '0;
    end else if (tick) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + RATE_W'(1);
    end
  end

  // Column rotation. Sampling happens at the end of the slot, just before
  // the index moves on. By then the synchroniser has had rate-2 cycles to
  // settle on the active column.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_idx <= 2'd0;
      mask0   <= 4'h0;
      mask1   <= 4'h0;
      mask2   <= 4'h0;
    end else if (tick) begin
      col_idx <= col_idx + 2'd1;
      case (col_idx)
        2'd0:    mask0 <= ~row_s;
        2'd1:    mask1 <= ~row_s;
        2'd2:    mask2 <= ~row_s;
        default: ;
      endcase
    end
  end

  assign col = ~(4'b0001 << col_idx);

  // A frame ends on the last column's tick. That column's rows are taken
  // live from the synchroniser rather than from a stored mask.
  assign frame_done = tick && (col_idx == 2'd3);

  always_comb begin
    snapshot = '0;
    for (int r = 0; r < 4; r++) begin
      snapshot[4*r + 0] = mask0[r];
      snapshot[4*r + 1] = mask1[r];
      snapshot[4*r + 2] = mask2[r];
      snapshot[4*r + 3] = ~row_s[r];
    end
  end

  // Count the set bits and remember the index of one of them. The index is
  // only meaningful when exactly one bit is set.
  always_comb begin
    bit_cnt     = '0;
    single_code = '0;
    for (int i = 0; i < 16; i++) begin
      if (snapshot[i]) begin
        bit_cnt     = bit_cnt + 5'd1;
        single_code = 4'(i);
      end
    end
  end

  assign snap_none   = (bit_cnt == 5'd0);
  assign snap_single = (bit_cnt == 5'd1);

  // Debounce state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      db_cnt <= 4'd0;
      cand   <= 4'd0;
    end else begin
      state  <= state_next;
      db_cnt <= db_cnt_next;
      cand   <= cand_next;
    end
  end

  // Debounce next-state logic, evaluated only at frame completion. HELD is
  // always entered with db_cnt cleared, so the release count starts fresh
  // even when DB_FRAMES is 1.
  always_comb begin
    state_next  = state;
    db_cnt_next = db_cnt;
    cand_next   = cand;
    emit        = 1'b0;
    emit_code   = cand;
    db_inc      = db_cnt + 4'd1;
    if (frame_done) begin
      case (state)
        IDLE: begin
          if (snap_single) begin
            cand_next = single_code;
            if (DB_LIMIT <= 4'd1) begin
              emit        = 1'b1;
              emit_code   = single_code;
              state_next  = HELD;
              db_cnt_next = 4'd0;
            end else begin
              state_next  = DEBOUNCE;
              db_cnt_next = 4'd1;
            end
          end
        end
        DEBOUNCE: begin
          if (snap_single && (single_code == cand)) begin
            if (db_inc >= DB_LIMIT) begin
              emit        = 1'b1;
              emit_code   = cand;
              state_next  = HELD;
              db_cnt_next = 4'd0;
            end else begin
              db_cnt_next = db_inc;
            end
          end else if (snap_single) begin
            cand_next   = single_code;
            db_cnt_next = 4'd1;
          end else begin
            state_next  = IDLE;
            db_cnt_next = 4'd0;
          end
        end
        HELD: begin
          if (snap_none) begin
            if (db_inc >= DB_LIMIT) begin
              state_next  = IDLE;
              db_cnt_next = 4'd0;
            end else begin
              db_cnt_next = db_inc;
            end
          end else begin
            db_cnt_next = 4'd0;
          end
        end
        default: begin
          state_next  = IDLE;
          db_cnt_next = 4'd0;
        end
      endcase
    end
  end

  // A key is dropped when it is emitted while an earlier key is still waiting
  // and the consumer is not taking that earlier key in the same cycle.
  assign drop = emit && key_valid && !key_ready;

  // Output holding register. key_code changes only when the slot is empty or
  // is being handed over in this cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_code  <= 4'd0;
      key_valid <= 1'b0;
    end else if (emit) begin
      if (!key_valid || key_ready) begin
        key_code  <= emit_code;
        key_valid <= 1'b1;
      end
    end else if (key_valid && key_ready) begin
      key_valid <= 1'b0;
    end
  end

  // Sticky overflow. A drop in the same cycle as a clear still sets the flag,
  // so software never misses a lost key.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow <= 1'b0;
    end else if (drop) begin
      overflow <= 1'b1;
    end else if (ovf_clr) begin
      overflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ssd_keypad_scan.sv
// tb_ssd_keypad_scan
//
// Directed bench for ssd_keypad_scan with rate = 4 and DB_FRAMES = 3.
// A behavioural keypad drives the row lines from the DUT column drive and a
// 16-bit pressed-key vector (bit 4*row+col). The bench counts clock edges
// since reset release in cyc. After edge n, col_idx = (n/4)%4, and frame k
// completes on edge 16*k. Samples are taken 1 time unit after each edge.

module tb_ssd_keypad_scan;

  localparam int RATE_W = 16;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [RATE_W-1:0] rate = 16'd4;
  logic [3:0]        row;
  logic [3:0]        col;
  logic [3:0]        key_code;
  logic              key_valid;
  logic              key_ready = 1'b0;
  logic              overflow;
  logic              ovf_clr = 1'b0;

  logic [15:0]       keys = 16'h0000;
  int                cyc;
  int                checks = 0;
  int                errors = 0;

  ssd_keypad_scan #(.RATE_W(RATE_W), .DB_FRAMES(3)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rate      (rate),
    .row       (row),
    .col       (col),
    .key_code  (key_code),
    .key_valid (key_valid),
    .key_ready (key_ready),
    .overflow  (overflow),
    .ovf_clr   (ovf_clr)
  );

  always #5 clk = ~clk;

  // Keypad model: a row goes low when a pressed key sits on a driven column.
  always_comb begin
    row = 4'hF;
    for (int r = 0; r < 4; r++) begin
      row[r] = ~|(keys[4*r +: 4] & ~col);
    end
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic wait_cyc(input int n);
    while (cyc < n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset(input logic [15:0] k);
    rst_n     = 1'b0;
    keys      = k;
    rate      = 16'd4;
    key_ready = 1'b0;
    ovf_clr   = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    keys  = 16'h0040;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (col !== 4'b1110) begin errors++; $display("[TB] FAIL reset_col: got %b expected 1110", col); end
    checks++; if (key_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid: got %b expected 0", key_valid); end
    checks++; if (key_code !== 4'd0) begin errors++; $display("[TB] FAIL reset_code: got %0d expected 0", key_code); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("[TB] FAIL reset_ovf: got %b expected 0", overflow); end
  endtask

  task automatic test_scan();
    logic [3:0] one;
    logic [3:0] exp_col;
    one = 4'b0001;
    do_reset(16'h0000);
    for (int n = 1; n <= 32; n++) begin
      wait_cyc(n);
      exp_col = ~(one << ((n / 4) % 4));
      checks++;
      if (col !== exp_col) begin
        errors++;
        $display("[TB] FAIL scan_col edge %0d: got %b expected %b", n, col, exp_col);
      end
    end
    for (int k = 1; k <= 10; k++) begin
      wait_cyc(16 * k + 1);
      checks++;
      if (key_valid !== 1'b0) begin
        errors++;
        $display("[TB] FAIL scan_no_key frame %0d: got %b expected 0", k, key_valid);
      end
    end
  endtask

  task automatic test_single_press();
    do_reset(16'h0040);
    wait_cyc(47);
    checks++; if (key_valid !== 1'b0) begin errors++; $display("[TB] FAIL press_early: got %b expected 0", key_valid); end
    wait_cyc(48);
    checks++; if (key_valid !== 1'b1) begin errors++; $display("[TB] FAIL press_valid: got %b expected 1", key_valid); end
    checks++; if (key_code !== 4'd6) begin errors++; $display("[TB] FAIL press_code: got %0d expected 6", key_code); end
    wait_cyc(60);
    checks++; if (key_valid !== 1'b1) begin errors++; $display("[TB] FAIL press_hold_valid: got %b expected 1", key_valid); end
    key_ready = 1'b1;
    wait_cyc(61);
    key_ready = 1'b0;
    checks++; if (key_valid !== 1'b0) begin errors++; $display("[TB] FAIL press_ack: got %b expected 0", key_valid); end
    checks++; if (key_code !== 4'd6) begin errors++; $display("[TB] FAIL press_code_kept: got %0d expected 6", key_code); end
    wait_cyc(81);
    checks++; if (key_valid !== 1'b0) begin errors++; $display("[TB] FAIL press_no_repeat: got %b expected 0", key_valid); end
    keys = 16'h0000;
  endtask

  task automatic test_bounce_release();
    logic [8:0] pat;
    logic       exp_v;
    // Frame k (1-based) is pressed when pat[k-1] is set: P P N P P N P P P.
    pat = 9'b111011011;
    do_reset(16'h0040);
    for (int k = 1; k <= 9; k++) begin
      wait_cyc(16 * k);
      exp_v = (k == 9);
      checks++;
      if (key_valid !== exp_v) begin
        errors++;
        $display("[TB] FAIL bounce_valid frame %0d: got %b expected %b", k, key_valid, exp_v);
      end
      if (k < 9) keys = pat[k] ? 16'h0040 : 16'h0000;
    end
    checks++; if (key_code !== 4'd6) begin errors++; $display("[TB] FAIL bounce_code: got %0d expected 6", key_code); end
    key_ready = 1'b1;
    keys      = 16'h0000;
    wait_cyc(145);
    key_ready = 1'b0;
    checks++; if (key_valid !== 1'b0) begin errors++; $display("[TB] FAIL bounce_ack: got %b expected 0", key_valid); end
    for (int k = 10; k <= 14; k++) begin
      wait_cyc(16 * k);
      checks++;
      if (key_valid !== 1'b0) begin
        errors++;
        $display("[TB] FAIL release_no_emit frame %0d: got %b expected 0", k, key_valid);
      end
      if (k == 11) keys = 16'h0040;
    end
    checks++; if (overflow !== 1'b0) begin errors++; $display("[TB] FAIL release_ovf: got %b expected 0", overflow); end
    keys = 16'h0000;
  endtask

  task automatic test_multi_overflow();
    do_reset(16'h0021);
    for (int k = 1; k <= 6; k++) begin
      wait_cyc(16 * k + 1);
      checks++;
      if (key_valid !== 1'b0) begin
        errors++;
        $display("[TB] FAIL multi_no_emit frame %0d: got %b expected 0", k, key_valid);
      end
    end
    wait_cyc(96);
    keys = 16'h8000;
    wait_cyc(144);
    checks++; if (key_valid !== 1'b1) begin errors++; $display("[TB] FAIL k15_valid: got %b expected 1", key_valid); end
    checks++; if (key_code !== 4'd15) begin errors++; $display("[TB] FAIL k15_code: got %0d expected 15", key_code); end
    keys = 16'h0000;
    wait_cyc(192);
    keys = 16'h8000;
    wait_cyc(239);
    checks++; if (overflow !== 1'b0) begin errors++; $display("[TB] FAIL ovf_early: got %b expected 0", overflow); end
    wait_cyc(240);
    checks++; if (overflow !== 1'b1) begin errors++; $display("[TB] FAIL ovf_set: got %b expected 1", overflow); end
    checks++; if (key_code !== 4'd15) begin errors++; $display("[TB] FAIL ovf_code: got %0d expected 15", key_code); end
    checks++; if (key_valid !== 1'b1) begin errors++; $display("[TB] FAIL ovf_valid: got %b expected 1", key_valid); end
    ovf_clr = 1'b1;
    keys    = 16'h0000;
    wait_cyc(241);
    ovf_clr = 1'b0;
    checks++; if (overflow !== 1'b0) begin errors++; $display("[TB] FAIL ovf_clear: got %b expected 0", overflow); end
    wait_cyc(288);
    keys = 16'h0010;
    wait_cyc(335);
    ovf_clr = 1'b1;
    wait_cyc(336);
    ovf_clr = 1'b0;
    checks++; if (overflow !== 1'b1) begin errors++; $display("[TB] FAIL ovf_set_wins: got %b expected 1", overflow); end
    checks++; if (key_code !== 4'd15) begin errors++; $display("[TB] FAIL drop_code_kept: got %0d expected 15", key_code); end
    key_ready = 1'b1;
    wait_cyc(337);
    key_ready = 1'b0;
    checks++; if (key_valid !== 1'b0) begin errors++; $display("[TB] FAIL ovf_ack: got %b expected 0", key_valid); end
    checks++; if (key_code !== 4'd15) begin errors++; $display("[TB] FAIL ack_code: got %0d expected 15", key_code); end
    keys = 16'h0000;
  endtask

  task automatic test_freeze_reset();
    do_reset(16'h0040);
    wait_cyc(48);
    checks++; if (key_valid !== 1'b1) begin errors++; $display("[TB] FAIL fr_valid: got %b expected 1", key_valid); end
    wait_cyc(54);
    checks++; if (col !== 4'b1101) begin errors++; $display("[TB] FAIL fr_col_pre: got %b expected 1101", col); end
    rate = 16'd0;
    for (int n = 55; n <= 74; n++) begin
      wait_cyc(n);
      checks++;
      if (col !== 4'b1101) begin
        errors++;
        $display("[TB] FAIL freeze_col edge %0d: got %b expected 1101", n, col);
      end
    end
    rate = 16'd4;
    wait_cyc(77);
    checks++; if (col !== 4'b1101) begin errors++; $display("[TB] FAIL resume_col_hold: got %b expected 1101", col); end
    wait_cyc(78);
    checks++; if (col !== 4'b1011) begin errors++; $display("[TB] FAIL resume_col_step: got %b expected 1011", col); end
    checks++; if (key_valid !== 1'b1) begin errors++; $display("[TB] FAIL pre_rst_valid: got %b expected 1", key_valid); end
    checks++; if (key_code !== 4'd6) begin errors++; $display("[TB] FAIL pre_rst_code: got %0d expected 6", key_code); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (col !== 4'b1110) begin errors++; $display("[TB] FAIL async_rst_col: got %b expected 1110", col); end
    checks++; if (key_valid !== 1'b0) begin errors++; $display("[TB] FAIL async_rst_valid: got %b expected 0", key_valid); end
    checks++; if (key_code !== 4'd0) begin errors++; $display("[TB] FAIL async_rst_code: got %0d expected 0", key_code); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("[TB] FAIL async_rst_ovf: got %b expected 0", overflow); end
    keys = 16'h0000;
  endtask

  initial begin
    test_reset();
    test_scan();
    test_single_press();
    test_bounce_release();
    test_multi_overflow();
    test_freeze_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
